priority_index_dispatch_8bit: RTL
=================================

// Module: priority_index_dispatch_8bit
// PURPOSE
//   Companion to the 8-bit priority encoder. Consumes {index, valid} events and buffers them in a small FIFO.
//   Decodes each index back to a one-hot line and hands it downstream over a valid/ready handshake.
//   Keeps a sticky per-line pending mask, cleared by per-line acks, and counts duplicate (re-raised) events.
//   Sits between the encoder output and the per-line service logic.
// PARAMETERS
//   WIDTH       8   number of one-hot lines
//   IDX_W       3   index width, = $clog2(WIDTH)
//   FIFO_DEPTH  4   index buffer entries (power of 2, >=2)
// PORTS
//   clk          in   1        rising-edge clock, single clock domain
//   rst          in   1        synchronous reset, active-high
//   in_idx       in   IDX_W    encoded line index from encoder
//   in_valid     in   1        in_idx is valid this cycle
//   in_ready     out  1        block can accept an index this cycle
//   out_onehot   out  WIDTH    decoded one-hot of FIFO head; all zeros when out_valid=0
//   out_valid    out  1        out_onehot holds a valid event
//   out_ready    in   1        downstream takes the event this cycle
//   ack          in   WIDTH    per-line service done; clears pending bit
//   pending      out  WIDTH    sticky mask of dispatched, un-acked lines
//   dup_cnt      out  8        count of dispatches to an already-pending line, saturating
// BEHAVIOUR
//   Clock and reset
//   - Single clock, clk.
//   - rst is synchronous and active-high; it is sampled on the rising edge of clk.
//   Reset
//   - Reset clears count, read pointer, write pointer, pending and dup_cnt.
//   - While rst=1: out_valid=0, out_onehot=0, in_ready=0.
//   - In the first cycle after rst deasserts, in_ready=1.
//   - Asserting rst mid-operation discards all buffered events. FIFO contents are not output afterwards.
//   Input side
//   - push = in_valid & in_ready.
//   - in_ready = (count != FIFO_DEPTH) & ~rst.
//   - When full, in_ready is low even if a pop happens in the same cycle. There is no pass-through.
//   - An index >= WIDTH is accepted (handshake completes) but is dropped: it is not written and count does not change.
//     This case only arises for WIDTH that is not a power of 2.
//   Output side
//   - out_valid = (count != 0).
//   - out_onehot = out_valid ? (1 << head_idx) : 0, where head_idx is the registered FIFO head entry.
//   - pop = out_valid & out_ready.
//   - Latency: an index pushed at edge N into an empty FIFO gives out_valid=1 in the cycle after edge N (1 cycle).
//   - Order is strict FIFO. Repeated identical indices are kept as separate events.
//   - Simultaneous push and pop when not full: count is unchanged and both pointers advance.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - out_onehot and out_valid hold stable while out_valid=1 and out_ready=0.
//   Pending mask and duplicates
//   - On pop of index i: pending[i] <= 1.
//   - ack[j]=1 clears pending[j]. Several ack bits may be high at once.
//   - Pop of i together with ack[i] in the same cycle: the set wins and pending[i]=1 afterwards.
//   - dup_cnt increments on a pop of i when pending[i]=1 before the edge, including when ack[i] is high that cycle.
//   - dup_cnt saturates at 255 and never wraps.
//   - ack to a line that is not pending has no effect.
// TESTING
//   1. Reset, then push idx=5 with out_ready=1.
//      -> Next cycle: out_valid=1, out_onehot=8'b0010_0000.
//      -> Cycle after: pending=8'h20, out_valid=0.
//   2. Hold out_ready=0 and push 3,7,0,1.
//      -> in_ready=0 after the 4th push. A 5th push is refused.
//      -> Then set out_ready=1: outputs 08,80,01,02 in that order, and in_ready returns to 1.
//   3. FIFO full, in the same cycle: in_valid=1, out_ready=1.
//      -> Pop occurs and push does not. count goes 4->3.
//      -> The next cycle's push succeeds.
//   4. Dispatch idx 2 twice with no ack -> dup_cnt=1, pending=8'h04.
//      Then ack[2]=1 in the same cycle as a third pop of 2 -> pending[2]=1, dup_cnt=2.
//   5. Assert rst for 1 cycle with 3 entries buffered and pending=8'hFF.
//      -> out_valid=0, pending=0, dup_cnt=0.
//      -> in_ready=1 in the next cycle, and no stale entries appear.
//   6. Force 256 duplicate dispatches to line 0 -> dup_cnt holds at 255.

Source files
------------

// File: rtl/priority_index_dispatch_8bit.sv
// Buffers encoded line indices, decodes the FIFO head to a one-hot event
// and tracks which dispatched lines are still awaiting service.
module priority_index_dispatch_8bit #(
    parameter int WIDTH      = 8,
    parameter int IDX_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [WIDTH-1:0] ack,
    output logic [WIDTH-1:0] pending,
    output logic [7:0]       dup_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [IDX_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic [WIDTH-1:0] r_pending;
    logic [7:0]       r_dup;

    logic             w_push;
    logic             w_idx_ok;
    logic             w_wr;
    logic             w_pop;
    logic             w_hit;
    logic [IDX_W-1:0] w_head;
    logic [WIDTH-1:0] w_onehot;

    assign in_ready  = (r_count != (PTR_W+1)'(FIFO_DEPTH)) & ~rst;
    assign out_valid = (r_count != '0) & ~rst;
    assign w_head    = r_mem[r_rptr];

    // Out-of-range indices complete the handshake but are never stored.
    assign w_idx_ok = {1'b0, in_idx} < (IDX_W+1)'(WIDTH);
    assign w_push   = in_valid & in_ready;
    assign w_wr     = w_push & w_idx_ok;
    assign w_pop    = out_valid & out_ready;

    always_comb begin
        w_onehot = '0;
        if (out_valid) begin
            w_onehot[w_head] = 1'b1;
        end
    end

    assign w_hit      = |(w_onehot & r_pending);
    assign out_onehot = w_onehot;
    assign pending    = r_pending;
    assign dup_cnt    = r_dup;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= in_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_pending <= '0;
            r_dup     <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A new dispatch outranks an ack to the same line.
            r_pending <= (r_pending & ~ack) | (w_pop ? w_onehot : '0);
            if (w_pop && w_hit && (r_dup != 8'hFF)) begin
                r_dup <= r_dup + 1'b1;
            end
        end
    end

endmodule
